seq_ctrl: RTL and testbench

- Sequence/timing controller for the basic computer.
- Owns the start-stop flag S, the sequence counter SC and the interrupt-cycle flag R.
- Decodes SC into one-hot timing signals T0..T15 that sequence every datapath register, memory and flag flip-flop (including the toggle-type flags).
- Sits between the instruction decoder/control logic and the datapath. Control logic requests SC clear or halt; this block decides when each timing step happens.

---
 rtl/seq_pkg.sv | 32 +++
 rtl/seq_decoder.sv | 15 +
 rtl/seq_ctrl.sv | 118 +++++++++++
 tb/tb_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and types for the basic-computer sequence controller:
// default SC width, named timing indices and the run/stop state type.
package seq_pkg;

  localparam int unsigned SC_WIDTH_DEF = 4;

  localparam int unsigned T0  = 0;
  localparam int unsigned T1  = 1;
  localparam int unsigned T2  = 2;
  localparam int unsigned T3  = 3;
  localparam int unsigned T4  = 4;
  localparam int unsigned T5  = 5;
  localparam int unsigned T6  = 6;
  localparam int unsigned T7  = 7;
  localparam int unsigned T8  = 8;
  localparam int unsigned T9  = 9;
  localparam int unsigned T10 = 10;
  localparam int unsigned T11 = 11;
  localparam int unsigned T12 = 12;
  localparam int unsigned T13 = 13;
  localparam int unsigned T14 = 14;
  localparam int unsigned T15 = 15;

  // Last timing step of the interrupt cycle (R.T2)
  localparam int unsigned INT_LAST_STEP = T2;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational SC -> one-hot timing decoder; all outputs low when en=0.
module seq_decoder #(
  parameter int unsigned W = 4
) (
  input  logic            en,
  input  logic [W-1:0]    sel,
  output logic [2**W-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/seq_ctrl.sv
// Sequence/timing controller: owns S, SC and R, and drives timing T0..Tn.
// Optional single-step support is built when SEQ_STEP_EN is defined.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned SC_WIDTH  = SC_WIDTH_DEF,
  parameter bit          RESET_RUN = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   sc_clr,
  input  logic                   ien,
  input  logic                   fgi,
  input  logic                   fgo,
`ifdef SEQ_STEP_EN
  input  logic                   step_mode,
  output logic                   step_done,
`endif
  output logic [2**SC_WIDTH-1:0] timing,
  output logic [SC_WIDTH-1:0]    sc_value,
  output logic                   running,
  output logic                   r_flag,
  output logic                   int_ack,
  output logic                   sc_wrap
);

  localparam logic [SC_WIDTH-1:0] SC_INT_LAST = SC_WIDTH'(INT_LAST_STEP);

  run_t                state, state_next;
  logic [SC_WIDTH-1:0] sc, sc_next;
  logic                r, r_next;
  logic                wrap, wrap_next;
  logic                int_cycle;
  logic                int_end;

  // The interrupt cycle proper is R with SC<=2; an R set at SC>=3 is only
  // pending, so sc_clr must still end the current instruction.
  assign int_cycle = r && (sc <= SC_INT_LAST);
  assign int_end   = r && (sc == SC_INT_LAST);

`ifdef SEQ_STEP_EN
  logic step_stop;
  assign step_stop = step_mode && (state == RUNNING) && !halt &&
                     (int_end || (sc_clr && !int_cycle));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_RUN ? RUNNING : STOPPED;
      sc    <= '0;
      r     <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
      r     <= r_next;
      wrap  <= wrap_next;
    end
  end

`ifdef SEQ_STEP_EN
  always_ff @(posedge clk) begin
    if (reset) step_done <= 1'b0;
    else       step_done <= step_stop;
  end
`endif

  always_comb begin
    state_next = state;
    sc_next    = sc;
    r_next     = r;
    wrap_next  = wrap;
    case (state)
      STOPPED: begin
        if (start) begin
          state_next = RUNNING;
          sc_next    = '0;
        end
      end
      RUNNING: begin
        if (!r && (sc > SC_INT_LAST) && ien && (fgi || fgo)) r_next = 1'b1;
        if (halt) begin
          state_next = STOPPED;
          sc_next    = '0;
        end else if (int_end) begin
          r_next  = 1'b0;
          sc_next = '0;
        end else if (int_cycle) begin
          sc_next = sc + 1'b1;
        end else if (sc_clr) begin
          sc_next = '0;
        end else begin
          sc_next = sc + 1'b1;
          if (&sc) wrap_next = 1'b1;
        end
`ifdef SEQ_STEP_EN
        if (step_stop) state_next = STOPPED;
`endif
      end
      default: state_next = STOPPED;
    endcase
  end

  seq_decoder #(.W(SC_WIDTH)) u_decoder (
    .en  (state == RUNNING),
    .sel (sc),
    .dec (timing)
  );

  assign sc_value = sc;
  assign running  = (state == RUNNING);
  assign r_flag   = r;
  assign int_ack  = (state == RUNNING) && int_end;
  assign sc_wrap  = wrap;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed vector table, hand-written
// wrap/reset sequences and randomized stimulus against a behavioural model.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, halt, sc_clr, ien, fgi, fgo;
  logic [15:0] timing;
  logic [3:0]  sc_value;
  logic        running, r_flag, int_ack, sc_wrap;
`ifdef SEQ_STEP_EN
  logic        step_mode = 1'b0;
  logic        step_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  seq_ctrl #(.SC_WIDTH(4), .RESET_RUN(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .halt     (halt),
    .sc_clr   (sc_clr),
    .ien      (ien),
    .fgi      (fgi),
    .fgo      (fgo),
`ifdef SEQ_STEP_EN
    .step_mode(step_mode),
    .step_done(step_done),
`endif
    .timing   (timing),
    .sc_value (sc_value),
    .running  (running),
    .r_flag   (r_flag),
    .int_ack  (int_ack),
    .sc_wrap  (sc_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, st, hl, clr, ie, fi, fo;
    bit run;
    int sc;
    bit r;
    bit wrap;
  } vec_t;

  vec_t vq[$];

  // Behavioural model state
  bit m_run, m_r, m_wrap;
  int m_sc;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit run, input int sc,
                           input bit r, input bit wrap);
    int exp_t;
    exp_t = run ? (1 << sc) : 0;
    chk({tag, ".timing"},  int'(timing),   exp_t);
    chk({tag, ".sc"},      int'(sc_value), sc);
    chk({tag, ".running"}, int'(running),  int'(run));
    chk({tag, ".r_flag"},  int'(r_flag),   int'(r));
    chk({tag, ".int_ack"}, int'(int_ack),  int'(run && r && sc == 2));
    chk({tag, ".sc_wrap"}, int'(sc_wrap),  int'(wrap));
  endtask

  task automatic drive(input bit rs, st, hl, cl, ie, fi, fo);
    reset = rs; start = st; halt = hl; sc_clr = cl; ien = ie; fgi = fi; fgo = fo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    bit set_r, in_int;
    if (reset) begin
      m_run = 1'b0; m_sc = 0; m_r = 1'b0; m_wrap = 1'b0;
    end else if (!m_run) begin
      if (start) begin m_run = 1'b1; m_sc = 0; end
    end else begin
      in_int = m_r && m_sc <= 2;
      set_r  = !m_r && m_sc >= 3 && ien && (fgi || fgo);
      if (halt) begin
        m_run = 1'b0; m_sc = 0;
      end else if (in_int && m_sc == 2) begin
        m_r = 1'b0; m_sc = 0;
      end else if (in_int || !sc_clr) begin
        if (!in_int && m_sc == 15) m_wrap = 1'b1;
        m_sc = (m_sc + 1) % 16;
      end else begin
        m_sc = 0;
      end
      if (set_r) m_r = 1'b1;
    end
  endtask

  initial begin
    //          rst st hl clr ie fi fo  run sc r wrap
    vq.push_back('{0,1,0,0,0,0,0, 1,0,0,0});  // start -> T0
    vq.push_back('{0,0,0,0,0,0,0, 1,1,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,2,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,3,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,4,0,0});
    vq.push_back('{0,0,0,1,0,0,0, 1,0,0,0});  // sc_clr at T4
    vq.push_back('{0,0,0,0,0,0,0, 1,1,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,2,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,3,0,0});
    vq.push_back('{0,0,0,0,1,1,0, 1,4,1,0});  // interrupt at T3
    vq.push_back('{0,0,0,0,0,0,0, 1,5,1,0});
    vq.push_back('{0,0,0,1,0,0,0, 1,0,1,0});  // sc_clr at T5 -> R.T0
    vq.push_back('{0,0,0,1,0,0,0, 1,1,1,0});  // sc_clr ignored in int cycle
    vq.push_back('{0,0,0,0,0,0,0, 1,2,1,0});  // R.T2, int_ack
    vq.push_back('{0,0,0,0,0,0,0, 1,0,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,1,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,2,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,3,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,4,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,5,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,6,0,0});
    vq.push_back('{0,0,1,0,0,0,0, 0,0,0,0});  // halt at T6
    vq.push_back('{0,0,0,1,1,1,1, 0,0,0,0});  // ignored while stopped
    vq.push_back('{0,1,0,0,0,0,0, 1,0,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,1,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,2,0,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,3,0,0});
    vq.push_back('{0,0,1,1,0,0,0, 0,0,0,0});  // halt+sc_clr at T3
    vq.push_back('{0,1,1,0,0,0,0, 1,0,0,0});  // start+halt while stopped
    vq.push_back('{0,1,1,0,0,0,0, 0,0,0,0});  // start+halt while running
    vq.push_back('{0,1,0,0,0,0,0, 1,0,0,0});
    vq.push_back('{0,0,0,0,1,0,1, 1,1,0,0});  // no R set at T0..T2
    vq.push_back('{0,0,0,0,1,0,1, 1,2,0,0});
    vq.push_back('{0,0,0,0,1,0,1, 1,3,0,0});
    vq.push_back('{0,0,0,0,1,0,1, 1,4,1,0});  // R set at T3 via fgo
    vq.push_back('{0,0,1,0,0,0,0, 0,0,1,0});  // halt keeps R
    vq.push_back('{0,1,0,0,0,0,0, 1,0,1,0});  // resume at R.T0
    vq.push_back('{0,0,0,0,0,0,0, 1,1,1,0});
    vq.push_back('{0,0,1,0,0,0,0, 0,0,1,0});  // halt in interrupt cycle
    vq.push_back('{0,1,0,0,0,0,0, 1,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,1,1,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,2,1,0});
    vq.push_back('{0,0,0,0,0,0,0, 1,0,0,0});

    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(0, vq[i].st, vq[i].hl, vq[i].clr, vq[i].ie, vq[i].fi, vq[i].fo);
      tick();
      check_all($sformatf("vec%0d", i), vq[i].run, vq[i].sc, vq[i].r, vq[i].wrap);
    end

    // SC wrap without clear: sticky until reset
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) tick();
    check_all("wrap.t15", 1, 15, 0, 0);
    tick();
    check_all("wrap.t0", 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 0); tick();
    check_all("wrap.held", 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    check_all("wrap.reset", 0, 0, 0, 0);

    // Reset in the middle of an interrupt cycle
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
    drive(0, 0, 0, 0, 1, 1, 0); tick();
    check_all("irq.t4", 1, 4, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check_all("irq.rt1", 1, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    check_all("irq.reset", 0, 0, 0, 0);

    // Randomized stimulus against the behavioural model
    m_run = 1'b0; m_sc = 0; m_r = 1'b0; m_wrap = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      model_step();
      tick();
      check_all($sformatf("rnd%0d", i), m_run, m_sc, m_r, m_wrap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
